// File: rtl/mdu.sv
// mdu: multiply/divide unit owning HI/LO.
// Multiplies take MUL_LAT busy cycles. Divides use a radix-2 restoring
// divider: WIDTH iteration cycles plus one sign-fix cycle.
module mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CMAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // multiply operands, extended by one bit so one signed multiplier covers both
  logic [WIDTH:0]   ma, mb;
  // divider datapath
  logic [WIDTH-1:0] rem, quo, dvs, araw;
  logic             qneg, rneg, dzero;

  // operand sign handling at issue
  logic sgn_mul, sgn_div, a_neg, b_neg;
  assign sgn_mul = (mdop == OP_MULT);
  assign sgn_div = (mdop == OP_DIV);
  assign a_neg   = sgn_div & src_a[WIDTH-1];
  assign b_neg   = sgn_div & src_b[WIDTH-1];

  // full product of the sign/zero extended operands; low 2*WIDTH bits are the result
  logic [2*WIDTH+1:0] prod;
  assign prod = $signed({{(WIDTH+1){ma[WIDTH]}}, ma}) * $signed({{(WIDTH+1){mb[WIDTH]}}, mb});

  // one restoring-division step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0] sh, diff;
  logic           fits;
  assign sh   = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign fits = (sh >= {1'b0, dvs});

  // main FSM: issue, multiply countdown, divide iteration, sign fix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      ma    <= '0;
      mb    <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      araw  <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      dzero <= 1'b0;
    end else if (flush) begin
      // abort: drop any partial result, HI/LO untouched
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdop)
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              OP_MULT, OP_MULTU: begin
                ma    <= {sgn_mul & src_a[WIDTH-1], src_a};
                mb    <= {sgn_mul & src_b[WIDTH-1], src_b};
                cnt   <= CW'(MUL_LAT - 1);
                state <= MUL;
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                quo   <= a_neg ? -src_a : src_a;
                dvs   <= b_neg ? -src_b : src_b;
                rem   <= '0;
                araw  <= src_a;
                qneg  <= a_neg ^ b_neg;
                rneg  <= a_neg;
                dzero <= (src_b == '0);
                cnt   <= CW'(WIDTH - 1);
                state <= DIV;
                busy  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= prod[2*WIDTH-1:0];
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          rem <= fits ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - CW'(1);
        end
        FIX: begin
          // divide-by-zero reports all-ones quotient and the raw dividend
          if (dzero) begin
            lo <= '1;
            hi <= araw;
          end else begin
            lo <= qneg ? -quo : quo;
            hi <= rneg ? -rem : rem;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed and randomized checks of mdu against a 64-bit arithmetic model.
module tb_mdu;
  localparam int W   = 32;
  localparam int LAT = 5;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         start = 0;
  logic [2:0]   mdop = 0;
  logic [W-1:0] src_a = 0, src_b = 0;
  logic         flush = 0;
  logic         busy;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mdu #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdop(mdop),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // the hazard unit must never issue while busy
  always @(posedge clk) begin
    if (rst_n && start && busy) begin
      failures++;
      $display("FAIL issue_while_busy: start=1 busy=1 required start=0");
    end
  end

  // reference model: expected HI/LO after op, in plain 64-bit arithmetic
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                inout logic [W-1:0] eh, el);
    longint sa, sb, sq, sr;
    longint unsigned up;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      3'd2: begin up = longint'(a) * longint'(b); p = up; eh = p[63:32]; el = p[31:0]; end
      3'd3, 3'd4: begin
        if (b == 0) begin el = '1; eh = a; end
        else if (op == 3'd3) begin
          sq = sa / sb; sr = sa % sb;
          el = sq[31:0]; eh = sr[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return LAT;
    if (op == 3'd3 || op == 3'd4) return W + 1;
    return 0;
  endfunction

  // issue one op from a negedge; count busy cycles; returns at the negedge busy is low
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, output int cyc);
    start = 1; mdop = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 0; mdop = 0;
    @(negedge clk);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  logic [W-1:0] eh = 0, el = 0;

  task automatic test_reset;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset: busy=%0b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    rst_n = 1;
    @(negedge clk);
    eh = 0; el = 0;
  endtask

  task automatic test_mul;
    int cyc;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 22; i++) begin
      if (i == 0)      begin op = 3'd1; a = 32'hFFFFFFFE; b = 32'd3; end
      else if (i == 1) begin op = 3'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
      else begin
        op = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2;
        a = $urandom; b = $urandom;
      end
      model(op, a, b, eh, el);
      run_op(op, a, b, cyc);
      checks++;
      if (cyc != LAT || hi !== eh || lo !== el) begin
        failures++;
        $display("FAIL mul op=%0d a=%h b=%h: busy=%0d hi=%h lo=%h required busy=%0d hi=%h lo=%h",
                 op, a, b, cyc, hi, lo, LAT, eh, el);
      end
    end
  endtask

  task automatic test_div;
    int cyc;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin op = 3'd3; a = 32'hFFFFFFF9; b = 32'd2; end
        1: begin op = 3'd4; a = 32'd7; b = 32'd2; end
        2: begin op = 3'd4; a = 32'h1234; b = 32'd0; end
        3: begin op = 3'd3; a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: begin op = 3'd3; a = 32'hFFFF0000; b = 32'd0; end
        default: begin
          op = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
          a = $urandom;
          b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
          if ($urandom_range(0, 1) == 0) b = -b;
        end
      endcase
      model(op, a, b, eh, el);
      run_op(op, a, b, cyc);
      checks++;
      if (cyc != W + 1 || hi !== eh || lo !== el) begin
        failures++;
        $display("FAIL div op=%0d a=%h b=%h: busy=%0d hi=%h lo=%h required busy=%0d hi=%h lo=%h",
                 op, a, b, cyc, hi, lo, W + 1, eh, el);
      end
    end
  endtask

  task automatic test_mt;
    int bsy = 0;
    start = 1; mdop = 3'd5; src_a = 32'hAAAA;
    @(posedge clk); #1;
    if (busy) bsy++;
    mdop = 3'd6; src_a = 32'h5555;
    @(posedge clk); #1;
    if (busy) bsy++;
    start = 0; mdop = 0;
    @(negedge clk);
    if (busy) bsy++;
    eh = 32'hAAAA; el = 32'h5555;
    checks++;
    if (hi !== eh || lo !== el || bsy != 0) begin
      failures++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h busy_seen=%0d required hi=%h lo=%h busy_seen=0",
               hi, lo, bsy, eh, el);
    end
    // NONE and reserved ops leave HI/LO alone
    run_op(3'd0, 32'h1, 32'h1, bsy);
    run_op(3'd7, 32'h2, 32'h2, bsy);
    checks++;
    if (hi !== eh || lo !== el || bsy != 0) begin
      failures++;
      $display("FAIL none_op: hi=%h lo=%h busy=%0d required hi=%h lo=%h busy=0", hi, lo, bsy, eh, el);
    end
  endtask

  task automatic test_flush;
    int cyc;
    start = 1; mdop = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 0; mdop = 0;
    repeat (10) @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL flush_div: busy=%0b hi=%h lo=%h required busy=0 hi=%h lo=%h", busy, hi, lo, eh, el);
    end
    // flush and start together: op not issued
    start = 1; flush = 1; mdop = 3'd5; src_a = 32'hDEAD;
    @(posedge clk); #1;
    start = 0; flush = 0; mdop = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== eh) begin
      failures++;
      $display("FAIL flush_start: busy=%0b hi=%h required busy=0 hi=%h", busy, hi, eh);
    end
    // unit still works after a flush
    model(3'd4, 32'd7, 32'd2, eh, el);
    run_op(3'd4, 32'd7, 32'd2, cyc);
    checks++;
    if (cyc != W + 1 || hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL after_flush: busy=%0d hi=%h lo=%h required busy=%0d hi=%h lo=%h",
               cyc, hi, lo, W + 1, eh, el);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    // second op issued on the very cycle busy falls
    model(3'd1, 32'd12345, 32'hFFFFFF00, eh, el);
    run_op(3'd1, 32'd12345, 32'hFFFFFF00, cyc);
    model(3'd4, 32'd1000, 32'd3, eh, el);
    run_op(3'd4, 32'd1000, 32'd3, cyc);
    checks++;
    if (cyc != W + 1 || hi !== eh || lo !== el) begin
      failures++;
      $display("FAIL back_to_back: busy=%0d hi=%h lo=%h required busy=%0d hi=%h lo=%h",
               cyc, hi, lo, W + 1, eh, el);
    end
  endtask

  task automatic test_reset_mid_mul;
    start = 1; mdop = 3'd2; src_a = 32'hFFFF; src_b = 32'hFFFF;
    @(posedge clk); #1;
    start = 0; mdop = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_mid_mul: busy=%0b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    eh = 0; el = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_mul;
    test_div;
    test_mt;
    test_flush;
    test_back_to_back;
    test_reset_mid_mul;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
